// File: rtl/doorlock_pkg.sv
// doorlock_pkg: state encoding and key constants shared by the door-lock controller
package doorlock_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT, S_PROGRAM
   } state_t;
   localparam int KEY_DIGIT = 0;
   localparam int KEY_ENTER = 1;
   localparam int KEY_CLEAR = 2;
   localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/doorlock_key_edge.sv
// key_edge: per-bit rising-edge detector over a registered history of debounced keys
module key_edge #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise
);
   logic [W-1:0] hist;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) hist <= '0;
      else hist <= d;
   assign rise = d & ~hist;
endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad code entry, password check, unlock timing and failure lockout.
// Define DOORLOCK_PW_CHANGE_EN to allow reprogramming the password from the OPEN state.
module doorlock_ctrl
   import doorlock_pkg::*;
#(
   parameter int                     CODE_LEN   = 4,
   parameter logic [CODE_LEN*4-1:0]  PW_DEFAULT = 16'h1234,
   parameter int unsigned            T_OPEN     = 150_000_000,
   parameter int unsigned            T_IDLE     = 500_000_000,
   parameter int unsigned            T_LOCKOUT  = 1_500_000_000,
   parameter int                     MAX_FAIL   = 3,
   parameter int                     CNT_W      = 31
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [2:0]            key_db,
   input  logic [3:0]            sw_digit,
   output logic                  unlock,
   output logic                  err,
   output logic                  locked_out,
   output logic [3:0]            digit_cnt,
   output logic [CODE_LEN*4-1:0] disp_code
);
   localparam int W = CODE_LEN * 4;
   localparam logic [CNT_W-1:0] T_OPEN_C = CNT_W'(T_OPEN);
   localparam logic [CNT_W-1:0] T_IDLE_C = CNT_W'(T_IDLE);
   localparam logic [CNT_W-1:0] T_LOCK_C = CNT_W'(T_LOCKOUT);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [3:0]       LEN4     = 4'(CODE_LEN);
   localparam logic [2:0]       MAX3     = 3'(MAX_FAIL);

   state_t           state, state_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [W-1:0]     code_buf, buf_n, shifted, pw;
   logic [3:0]       cnt_n;
   logic [2:0]       fail_cnt, fail_n;
   logic [2:0]       rise;
   logic             p_clr, p_ent, p_dig, dig_ok, dig_take;

   key_edge #(.W(3)) u_key_edge (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (key_db),
      .rise  (rise)
   );

   // clear beats enter beats digit; losers are dropped, not deferred
   assign p_clr    = rise[KEY_CLEAR];
   assign p_ent    = rise[KEY_ENTER] & ~p_clr;
   assign p_dig    = rise[KEY_DIGIT] & ~rise[KEY_ENTER] & ~p_clr;
   assign dig_ok   = p_dig && (sw_digit <= BCD_MAX);
   assign dig_take = dig_ok && (digit_cnt < LEN4);
   assign shifted  = {code_buf[W-5:0], sw_digit};
   assign disp_code = code_buf;

`ifdef DOORLOCK_PW_CHANGE_EN
   logic [W-1:0] pw_n;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) pw <= PW_DEFAULT;
      else pw <= pw_n;
`else
   assign pw = PW_DEFAULT;
`endif

   always_comb begin
      state_n = state;
      timer_n = timer;
      buf_n   = code_buf;
      cnt_n   = digit_cnt;
      fail_n  = fail_cnt;
`ifdef DOORLOCK_PW_CHANGE_EN
      pw_n    = pw;
`endif
      case (state)
         S_IDLE:
            if (dig_ok) begin
               buf_n   = shifted;
               cnt_n   = 4'd1;
               timer_n = T_IDLE_C;
               state_n = S_ENTRY;
            end
         S_ENTRY, S_PROGRAM: begin
            if (p_ent && state == S_ENTRY) begin
               state_n = S_CHECK;
            end else if (p_clr || p_ent || (!dig_take && timer == ONE)) begin
`ifdef DOORLOCK_PW_CHANGE_EN
               if (p_ent && digit_cnt == LEN4) pw_n = code_buf;
`endif
               buf_n   = '0;
               cnt_n   = '0;
               state_n = S_IDLE;
            end else if (dig_take) begin
               buf_n   = shifted;
               cnt_n   = digit_cnt + 4'd1;
               timer_n = T_IDLE_C;
            end else begin
               timer_n = timer - ONE;
            end
         end
         S_CHECK: begin
            buf_n = '0;
            cnt_n = '0;
            if (digit_cnt == LEN4 && code_buf == pw) begin
               fail_n  = '0;
               timer_n = T_OPEN_C;
               state_n = S_OPEN;
            end else begin
               state_n = S_FAIL;
            end
         end
         S_FAIL: begin
            fail_n  = fail_cnt + 3'd1;
            state_n = (fail_n == MAX3) ? S_LOCKOUT : S_IDLE;
            timer_n = (fail_n == MAX3) ? T_LOCK_C : timer;
         end
         S_OPEN:
`ifdef DOORLOCK_PW_CHANGE_EN
            if (p_clr) begin
               timer_n = T_IDLE_C;
               state_n = S_PROGRAM;
            end else
`endif
            if (timer == ONE) state_n = S_IDLE;
            else timer_n = timer - ONE;
         S_LOCKOUT:
            if (timer == ONE) begin
               fail_n  = '0;
               state_n = S_IDLE;
            end else begin
               timer_n = timer - ONE;
            end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         code_buf   <= '0;
         digit_cnt  <= '0;
         fail_cnt   <= '0;
         unlock     <= 1'b0;
         err        <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         code_buf   <= buf_n;
         digit_cnt  <= cnt_n;
         fail_cnt   <= fail_n;
         unlock     <= (state_n == S_OPEN);
         err        <= (state_n == S_FAIL);
         locked_out <= (state_n == S_LOCKOUT);
      end
endmodule
